// File: rtl/ram8k_bus_master_if.sv
// Command, write-stream, read-stream and RAM control bundle for ram8k_bus_master.
// The master modport is the bus master's view. The slave modport is the view
// of the fabric and the RAM that sit on the other side.
interface ram8k_bus_master_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              ce;
    logic              oce;
    logic              wre;
    logic [ADDR_W-1:0] ad;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_data, wr_valid,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
        output ce, oce, wre, ad
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_data, wr_valid,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
        input  ce, oce, wre, ad
    );
endinterface

// File: rtl/ram8k_bus_master.sv
// Single-master initiator for the 8 KB tri-state RAM port.
// It turns (addr, len, dir) commands into back-to-back single-beat RAM cycles.
// The RAM returns read data one cycle after a read cycle.
// The master samples that data one cycle later still, so rd_valid/rd_data
// come two cycles after the bus read cycle.
// Optional macro RAM_MASTER_TURNAROUND_EN adds a TURN state after each write
// burst. TURN is one extra idle bus cycle before IDLE, and it delays done by one cycle.
//
// state   | meaning
// IDLE    | waiting for a command; cmd_ready high
// WRITE   | taking write beats; each taken beat becomes a bus write next cycle
// WLAST   | final bus write cycle is on the bus
// READ    | issuing one bus read per cycle, no bubbles
// RDRAIN  | first cycle holds ce/oce so the RAM keeps driving the last datum,
//         | second cycle finishes the command
// TURN    | (macro only) one idle bus cycle after a write burst
module ram8k_bus_master #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    ram8k_bus_master_if.master bus,
    inout  wire [DATA_W-1:0]  data_bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WLAST, S_READ, S_RDRAIN, S_TURN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  count;
    logic              drain_2nd;
    logic              issue_q;
    logic              capture_q;
    logic              ce_q;
    logic              oce_q;
    logic              wre_q;
    logic [ADDR_W-1:0] ad_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              done_q;

    // Sequencer, registered RAM controls and read capture pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            count      <= '0;
            drain_2nd  <= 1'b0;
            issue_q    <= 1'b0;
            capture_q  <= 1'b0;
            ce_q       <= 1'b0;
            oce_q      <= 1'b0;
            wre_q      <= 1'b0;
            ad_q       <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ce_q       <= 1'b0;
            oce_q      <= 1'b0;
            wre_q      <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            issue_q    <= 1'b0;
            // issue_q marks a real read cycle on the bus; the RAM answers
            // in the next cycle, which is the cycle that capture_q covers.
            // The drain hold cycle never sets issue_q, so its repeated
            // datum is never captured.
            capture_q  <= issue_q;
            if (capture_q) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= data_bus;
            end
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        addr  <= bus.cmd_addr;
                        count <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else if (bus.cmd_we) begin
                            state <= S_WRITE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.wr_valid) begin
                        ce_q    <= 1'b1;
                        wre_q   <= 1'b1;
                        ad_q    <= addr;
                        wdata_q <= bus.wr_data;
                        addr    <= addr + 1'b1;
                        count   <= count - 1'b1;
                        if (count == LEN_W'(1)) begin
                            state <= S_WLAST;
                        end
                    end
                end
                S_WLAST: begin
`ifdef RAM_MASTER_TURNAROUND_EN
                    state <= S_TURN;
`else
                    state  <= S_IDLE;
                    done_q <= 1'b1;
`endif
                end
                S_TURN: begin
                    state  <= S_IDLE;
                    done_q <= 1'b1;
                end
                S_READ: begin
                    ce_q    <= 1'b1;
                    oce_q   <= 1'b1;
                    ad_q    <= addr;
                    issue_q <= 1'b1;
                    addr    <= addr + 1'b1;
                    count   <= count - 1'b1;
                    if (count == LEN_W'(1)) begin
                        state     <= S_RDRAIN;
                        drain_2nd <= 1'b0;
                    end
                end
                S_RDRAIN: begin
                    if (!drain_2nd) begin
                        ce_q      <= 1'b1;
                        oce_q     <= 1'b1;
                        drain_2nd <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake and status decode from the state register
    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.wr_ready  = (state == S_WRITE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.ce        = ce_q;
    assign bus.oce       = oce_q;
    assign bus.wre       = wre_q;
    assign bus.ad        = ad_q;

    // The master drives the bus only during its own registered write cycles
    assign data_bus = wre_q ? wdata_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_ram8k_bus_master.sv
// Bench for ram8k_bus_master.
// An expected-trace model is filled from the command timing rules.
// A negedge process compares the DUT against that model on every cycle.
// Directed tests then pin the model with hand-computed literal values.
// A bench RAM answers reads one cycle late. A weak keeper value (A5)
// shows whether the master has released the bus.
module tb_ram8k_bus_master;
    localparam int NCYC = 1024;

    logic clk = 1'b0;
    logic reset;
    wire [7:0] data_bus;
    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    ram8k_bus_master_if #(.ADDR_W(13), .DATA_W(8), .LEN_W(8)) bus ();

    ram8k_bus_master #(.ADDR_W(13), .DATA_W(8), .LEN_W(8)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .data_bus (data_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bench RAM: registered read, drives the bus the cycle after a read cycle
    logic [7:0] ram_mem [8192];
    logic       ram_oe = 1'b0;
    logic [7:0] ram_q = 8'h00;
    always @(posedge clk) begin
        ram_oe <= bus.ce && bus.oce && !bus.wre;
        if (bus.ce && bus.oce && !bus.wre) ram_q <= ram_mem[bus.ad];
        if (bus.ce && bus.wre) ram_mem[bus.ad] <= data_bus;
    end
    assign data_bus = (ram_oe && !bus.wre) ? ram_q : (!bus.wre ? 8'hA5 : 8'hzz);

    // expected trace, indexed by cycle
    bit         exp_ce [NCYC];
    bit         exp_oce [NCYC];
    bit         exp_wre [NCYC];
    bit         exp_busy [NCYC];
    bit         exp_rdy [NCYC];
    bit         exp_wrr [NCYC];
    bit         exp_rdv [NCYC];
    bit         exp_done [NCYC];
    logic [12:0] exp_ad [NCYC];
    logic [7:0]  exp_wd [NCYC];
    logic [7:0]  exp_rdd [NCYC];
    logic [7:0]  exp_mem [8192];

    // observation logs for literal checks
    int          wr_cyc_q[$];
    logic [12:0] wr_ad_q[$];
    int          rdbus_cyc_q[$];
    int          ce_cyc_q[$];
    int          rd_cyc_q[$];
    logic [7:0]  rd_dat_q[$];
    int          done_cyc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic clear_exp(input int from, input int upto);
        for (int c = from; c <= upto && c < NCYC; c++) begin
            exp_ce[c] = 0; exp_oce[c] = 0; exp_wre[c] = 0; exp_busy[c] = 0;
            exp_rdy[c] = 1; exp_wrr[c] = 0; exp_rdv[c] = 0; exp_done[c] = 0;
        end
    endtask

    task automatic clear_logs();
        wr_cyc_q.delete(); wr_ad_q.delete(); rdbus_cyc_q.delete(); ce_cyc_q.delete();
        rd_cyc_q.delete(); rd_dat_q.delete(); done_cyc_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // read command accepted in cycle a: n bus reads from a+2, one hold cycle,
    // data from a+4, done with the final datum
    task automatic model_read(input int a, input logic [12:0] addr, input int n);
        logic [12:0] ad;
        if (n == 0) begin
            exp_done[a+1] = 1;
        end else begin
            for (int j = 1; j <= n + 2; j++) begin
                exp_busy[a+j] = 1; exp_rdy[a+j] = 0;
            end
            for (int k = 0; k < n; k++) begin
                ad = addr + 13'(k);
                exp_ce[a+2+k] = 1; exp_oce[a+2+k] = 1; exp_ad[a+2+k] = ad;
                exp_rdv[a+4+k] = 1; exp_rdd[a+4+k] = exp_mem[ad];
            end
            exp_ce[a+n+2] = 1; exp_oce[a+n+2] = 1; exp_ad[a+n+2] = addr + 13'(n - 1);
            exp_done[a+n+3] = 1;
        end
    endtask

    // returns in the last busy cycle; the next step() lands on the done cycle
    task automatic do_read(input logic [12:0] addr, input int n, output int a);
        step();
        a = cyc;
        bus.cmd_valid = 1; bus.cmd_we = 0; bus.cmd_addr = addr; bus.cmd_len = 8'(n);
        bus.wr_valid = 1; bus.wr_data = 8'hEE;
        model_read(a, addr, n);
        step();
        bus.cmd_addr = 13'h1234; bus.cmd_len = 8'd9;
        if (n > 0) repeat (n + 1) step();
        bus.cmd_valid = 0; bus.wr_valid = 0;
    endtask

    // vpat bit i = wr_valid in the i-th WRITE cycle; data beats packed in dpk
    task automatic do_write(input logic [12:0] addr, input int n, input logic [15:0] vpat,
                            input logic [31:0] dpk);
        int a, k, i, t;
        logic [12:0] ad;
        step();
        a = cyc;
        bus.cmd_valid = 1; bus.cmd_we = 1; bus.cmd_addr = addr; bus.cmd_len = 8'(n);
        step();
        bus.cmd_we = 0; bus.cmd_addr = 13'h0ABC; bus.cmd_len = 8'd5;
        k = 0; i = 0; t = a;
        while (k < n && i < 16) begin
            exp_busy[cyc] = 1; exp_rdy[cyc] = 0; exp_wrr[cyc] = 1;
            bus.wr_valid = vpat[i];
            bus.wr_data = vpat[i] ? dpk[8*k +: 8] : 8'hEE;
            if (vpat[i]) begin
                ad = addr + 13'(k);
                exp_ce[cyc+1] = 1; exp_wre[cyc+1] = 1; exp_ad[cyc+1] = ad;
                exp_wd[cyc+1] = bus.wr_data; exp_mem[ad] = bus.wr_data;
                t = cyc; k++;
            end
            i++;
            step();
        end
        bus.wr_valid = 0; bus.cmd_valid = 0;
        exp_busy[t+1] = 1; exp_rdy[t+1] = 0;
`ifdef RAM_MASTER_TURNAROUND_EN
        exp_busy[t+2] = 1; exp_rdy[t+2] = 0; exp_done[t+3] = 1;
        step();
`else
        exp_done[t+2] = 1;
`endif
    endtask

    // per-cycle comparison against the expected trace
    always @(negedge clk) begin
        if (chk_en && cyc < NCYC) begin
            chk("ce", bus.ce, exp_ce[cyc]);
            chk("oce", bus.oce, exp_oce[cyc]);
            chk("wre", bus.wre, exp_wre[cyc]);
            chk("busy", bus.busy, exp_busy[cyc]);
            chk("cmd_ready", bus.cmd_ready, exp_rdy[cyc]);
            chk("wr_ready", bus.wr_ready, exp_wrr[cyc]);
            chk("rd_valid", bus.rd_valid, exp_rdv[cyc]);
            chk("done", bus.done, exp_done[cyc]);
            if (exp_ce[cyc]) chk("ad", bus.ad, exp_ad[cyc]);
            if (exp_wre[cyc]) chk("bus_wdata", data_bus, exp_wd[cyc]);
            if (exp_rdv[cyc]) chk("rd_data", bus.rd_data, exp_rdd[cyc]);
            if (!ram_oe && !exp_wre[cyc]) chk("bus_release", data_bus, 8'hA5);
            if (bus.ce) ce_cyc_q.push_back(cyc);
            if (bus.ce && bus.wre) begin wr_cyc_q.push_back(cyc); wr_ad_q.push_back(bus.ad); end
            if (bus.ce && bus.oce && !bus.wre) rdbus_cyc_q.push_back(cyc);
            if (bus.rd_valid) begin rd_cyc_q.push_back(cyc); rd_dat_q.push_back(bus.rd_data); end
            if (bus.done) done_cyc_q.push_back(cyc);
        end
    end

    initial begin
        int a;
        int gap;
        clear_exp(0, NCYC - 1);
        for (int m = 0; m < 8192; m++) exp_mem[m] = 8'h00;
        reset = 1;
        bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 0; bus.wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        chk_en = 1;
        chk("rst_ce", bus.ce, 0);
        chk("rst_wre", bus.wre, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);

        // write 4 beats at 0x0010, wr_valid always high
        clear_logs();
        do_write(13'h0010, 4, 16'h000F, 32'h44332211);
        repeat (3) step();
        chk("w4_count", wr_ad_q.size(), 4);
        chk("w4_ad0", wr_ad_q[0], 13'h0010);
        chk("w4_ad3", wr_ad_q[3], 13'h0013);
        chk("w4_contig", wr_cyc_q[3] - wr_cyc_q[0], 3);
        chk("w4_done_n", done_cyc_q.size(), 1);

        // read back 4 at 0x0010
        clear_logs();
        do_read(13'h0010, 4, a);
        repeat (3) step();
        chk("r4_count", rd_dat_q.size(), 4);
        chk("r4_first_cyc", rd_cyc_q[0] - a, 4);
        chk("r4_last_cyc", rd_cyc_q[3] - a, 7);
        chk("r4_d0", rd_dat_q[0], 8'h11);
        chk("r4_d1", rd_dat_q[1], 8'h22);
        chk("r4_d2", rd_dat_q[2], 8'h33);
        chk("r4_d3", rd_dat_q[3], 8'h44);
        chk("r4_done_cyc", done_cyc_q[0], rd_cyc_q[3]);

        // write 3 across the top of memory with two idle beats
        clear_logs();
        do_write(13'h1FFE, 3, 16'h0019, 32'h00CCBBAA);
        repeat (3) step();
        chk("wrap_ad0", wr_ad_q[0], 13'h1FFE);
        chk("wrap_ad1", wr_ad_q[1], 13'h1FFF);
        chk("wrap_ad2", wr_ad_q[2], 13'h0000);
        chk("wrap_bubbles", wr_cyc_q[2] - wr_cyc_q[0] + 1 - 3, 2);
        clear_logs();
        do_read(13'h1FFE, 3, a);
        repeat (3) step();
        chk("wrap_rd0", rd_dat_q[0], 8'hAA);
        chk("wrap_rd2", rd_dat_q[2], 8'hCC);

        // zero-length read
        clear_logs();
        do_read(13'h0020, 0, a);
        repeat (2) step();
        chk("len0_done_cyc", done_cyc_q[0] - a, 1);
        chk("len0_no_ce", ce_cyc_q.size(), 0);

        // write immediately followed by read
        clear_logs();
        do_write(13'h0100, 2, 16'h0003, 32'h00003C5A);
        do_read(13'h0100, 2, a);
        repeat (3) step();
        chk("wr_rd_accept_on_done", done_cyc_q[0], a);
`ifdef RAM_MASTER_TURNAROUND_EN
        gap = 4;
`else
        gap = 3;
`endif
        chk("wr_rd_gap", rdbus_cyc_q[0] - wr_cyc_q[1], gap);
        chk("wr_rd_d0", rd_dat_q[0], 8'h5A);
        chk("wr_rd_d1", rd_dat_q[1], 8'h3C);

        // reset held 3 cycles in the middle of an 8-beat read
        clear_logs();
        step();
        a = cyc;
        bus.cmd_valid = 1; bus.cmd_we = 0; bus.cmd_addr = 13'h0010; bus.cmd_len = 8'd8;
        model_read(a, 13'h0010, 8);
        step();
        bus.cmd_valid = 0;
        repeat (4) step();
        reset = 1;
        clear_exp(a + 6, a + 40);
        repeat (3) step();
        reset = 0;
        chk("mid_rst_ce", bus.ce, 0);
        chk("mid_rst_busy", bus.busy, 0);
        repeat (12) step();
        chk("mid_rst_rd_n", rd_dat_q.size(), 2);
        chk("mid_rst_no_done", done_cyc_q.size(), 0);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
